// File: rtl/rv32_multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: decodes the latched instruction and
// sequences the shared datapath and the unified memory port, with a memory-wait timeout.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | OldPC+imm into ALUOut (branch target), dispatch on opcode
// MEMADR   | rs1+imm address for load/store
// MEMREAD  | load access, wait for mem_ready
// MEMWB    | write loaded data to rd
// MEMWRITE | store access, wait for mem_ready
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | write ALU result to rd
// BRANCH   | compare rs1/rs2, take branch from ALUOut
// JAL      | PC <= ALUOut, compute OldPC+4 for rd
// FAULT    | illegal instruction or memory timeout, exits only via reset
module rv32_multicycle_ctrl #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] imm_src,
  output logic       fault,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_FAULT    = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam bit TIMEOUT_EN = (WAIT_LIMIT > 0);
  localparam int CNT_W = TIMEOUT_EN ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(WAIT_LIMIT - 1) : '0;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             fault_q;
  logic             waiting;
  logic             timeout;
  logic             funct_ok;
  logic [2:0]       alu_funct;
  logic             branch_ok;

  assign waiting   = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timeout   = TIMEOUT_EN && waiting && !mem_ready && (wait_cnt == CNT_LAST);
  assign branch_ok = (funct3 == 3'b000) || (funct3 == 3'b001);

  always_comb begin
    alu_funct = ALU_ADD;
    funct_ok  = 1'b1;
    case (funct3)
      3'b000:  alu_funct = (opcode[5] && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_funct = ALU_SLT;
      3'b110:  alu_funct = ALU_OR;
      3'b111:  alu_funct = ALU_AND;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    state_nxt = mem_ready ? S_DECODE : (timeout ? S_FAULT : S_FETCH);
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          default:           state_nxt = S_FAULT;
        endcase
      end
      S_MEMADR:   state_nxt = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nxt = mem_ready ? S_MEMWB : (timeout ? S_FAULT : S_MEMREAD);
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = mem_ready ? S_FETCH : (timeout ? S_FAULT : S_MEMWRITE);
      S_EXECR,
      S_EXECI:    state_nxt = funct_ok ? S_ALUWB : S_FAULT;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = branch_ok ? S_FETCH : S_FAULT;
      S_JAL:      state_nxt = S_ALUWB;
      default:    state_nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_FAULT) fault_q <= 1'b1;
      // A fresh wait window starts whenever a memory-wait state is entered from elsewhere.
      if ((state_nxt != state) &&
          ((state_nxt == S_FETCH) || (state_nxt == S_MEMREAD) || (state_nxt == S_MEMWRITE)))
        wait_cnt <= '0;
      else if (TIMEOUT_EN && waiting && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALU;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    imm_src    = 2'b00;
    fault      = fault_q;
    state_o    = state;
    case (opcode)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        result_src = RES_PC4;
        alu_src_b  = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_ctrl  = alu_funct;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = alu_funct;
      end
      S_ALUWB:  reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_ctrl  = ALU_SUB;
        pc_write  = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default:  imm_src = 2'b00;
    endcase
    // Nothing escapes while reset is asserted, including an in-flight memory request.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_ctrl   = 3'b000;
      imm_src    = 2'b00;
      fault      = 1'b0;
      state_o    = 4'd0;
    end
  end

endmodule
